// File: rtl/alu_scheduler.sv
// Round-robin scheduler that shares one combinational ALU between NREQ requesters.
// Each request is granted, executed for one cycle, then held as a response until accepted.
module alu_scheduler #(
   parameter int NREQ = 2,
   parameter int W    = 8,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [4*NREQ-1:0]   req_op,
   input  logic [W*NREQ-1:0]   req_a,
   input  logic [W*NREQ-1:0]   req_b,
   output logic [3:0]          alu_op,
   output logic [W-1:0]        alu_a,
   output logic [W-1:0]        alu_b,
   input  logic [W-1:0]        alu_result,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [W-1:0]        rsp_data,
   output logic                rsp_err,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} stateE;

   stateE          state, stateNext;
   logic [IDW-1:0] lastGrant, winner, scanIdx;
   logic           found, grant;
   logic [3:0]     issueOp;
   logic [W-1:0]   issueA, issueB;
   logic [IDW-1:0] issueId;
   logic           opIllegal;

   // Scan from the requester after the last winner so every requester gets a turn.
   always_comb begin
      winner  = '0;
      found   = 1'b0;
      scanIdx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         scanIdx = IDW'((int'(lastGrant) + k) % NREQ);
         if (!found && req_valid[scanIdx]) begin
            found  = 1'b1;
            winner = scanIdx;
         end
      end
   end

   assign grant = (state == IDLE) && found;

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (grant) stateNext = EXEC;
         EXEC:    stateNext = RESP;
         RESP:    if (rsp_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign opIllegal = (issueOp > 4'h9);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrant <= IDW'(NREQ - 1);
         issueOp   <= '0;
         issueA    <= '0;
         issueB    <= '0;
         issueId   <= '0;
         rsp_data  <= '0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
      end else begin
         if (grant) begin
            issueOp   <= req_op[4*int'(winner) +: 4];
            issueA    <= req_a[W*int'(winner) +: W];
            issueB    <= req_b[W*int'(winner) +: W];
            issueId   <= winner;
            lastGrant <= winner;
         end
         // The ALU output is valid one cycle after issue; illegal opcodes report zero data.
         if (state == EXEC) begin
            rsp_data <= opIllegal ? '0 : alu_result;
            rsp_id   <= issueId;
            rsp_err  <= opIllegal;
         end
      end
   end

   assign alu_op    = issueOp;
   assign alu_a     = issueA;
   assign alu_b     = issueB;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed testbench for alu_scheduler with a small behavioural ALU attached.
module tb_alu_scheduler;

   localparam int NREQ = 2;
   localparam int W    = 8;
   localparam logic [3:0] kADD = 4'h0, kSUB = 4'h1, kAND = 4'h2, kOR = 4'h3, kXOR = 4'h4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NREQ-1:0] reqValid;
   logic [NREQ-1:0] reqReady;
   logic [4*NREQ-1:0] reqOp;
   logic [W*NREQ-1:0] reqA, reqB;
   logic [3:0]      aluOp;
   logic [W-1:0]    aluA, aluB, aluResult;
   logic            rspValid, rspReady, rspErr, busy;
   logic [0:0]      rspId;
   logic [W-1:0]    rspData;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(reqValid), .req_ready(reqReady),
      .req_op(reqOp), .req_a(reqA), .req_b(reqB),
      .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB), .alu_result(aluResult),
      .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_id(rspId),
      .rsp_data(rspData), .rsp_err(rspErr), .busy(busy)
   );

   // Illegal opcodes give a nonzero pattern so a missing zeroing shows up.
   always_comb begin
      case (aluOp)
         4'h0:    aluResult = aluA + aluB;
         4'h1:    aluResult = aluA - aluB;
         4'h2:    aluResult = aluA & aluB;
         4'h3:    aluResult = aluA | aluB;
         4'h4:    aluResult = aluA ^ aluB;
         default: aluResult = aluA ^ aluB ^ 8'h5A;
      endcase
   end

   task automatic setReq(input int i, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic v);
      reqOp[4*i +: 4] = op;
      reqA[W*i +: W]  = a;
      reqB[W*i +: W]  = b;
      reqValid[i]     = v;
   endtask

   task automatic waitRsp(output bit ok);
      int n = 0;
      while (!rspValid && n < 12) begin
         @(negedge clk);
         n++;
      end
      ok = rspValid;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; reqValid = '0; reqOp = '0; reqA = '0; reqB = '0; rspReady = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({rspValid, busy, reqReady, aluOp, rspData, rspErr} !== '0) begin
         fails++;
         $display("FAIL reset_state: got v=%b busy=%b rdy=%b op=%h data=%h err=%b required all 0",
                  rspValid, busy, reqReady, aluOp, rspData, rspErr);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single;
      rspReady = 1'b1;
      setReq(0, kADD, 8'h05, 8'h03, 1'b1);
      #1;
      tests++;
      if (reqReady !== 2'b01) begin
         fails++; $display("FAIL single_grant: got %b required 01", reqReady);
      end
      @(negedge clk);
      reqValid[0] = 1'b0;
      tests++;
      if ({busy, rspValid, reqReady} !== 4'b1000) begin
         fails++; $display("FAIL single_exec: got busy=%b v=%b rdy=%b required 1 0 00", busy, rspValid, reqReady);
      end
      @(negedge clk);
      tests++;
      if ({rspValid, rspData, rspId, rspErr} !== {1'b1, 8'h08, 1'b0, 1'b0}) begin
         fails++; $display("FAIL single_rsp: got v=%b data=%h id=%h err=%b required 1 08 0 0",
                           rspValid, rspData, rspId, rspErr);
      end
      tests++;
      if ({aluOp, aluA, aluB} !== {kADD, 8'h05, 8'h03}) begin
         fails++; $display("FAIL single_issue: got op=%h a=%h b=%h required 0 05 03", aluOp, aluA, aluB);
      end
      @(negedge clk);
      tests++;
      if ({rspValid, busy} !== 2'b00) begin
         fails++; $display("FAIL single_done: got v=%b busy=%b required 0 0", rspValid, busy);
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      rspReady = 1'b0;
      setReq(0, kADD, 8'h10, 8'h20, 1'b1);
      @(negedge clk);
      reqValid[0] = 1'b0;
      setReq(1, kOR, 8'h0C, 8'h30, 1'b1);
      waitRsp(ok);
      tests++;
      if (!ok) begin
         fails++; $display("FAIL bp_timeout: got no rsp_valid required rsp_valid=1");
      end
      for (int c = 0; c < 5; c++) begin
         tests++;
         if ({rspValid, rspData, rspId, reqReady} !== {1'b1, 8'h30, 1'b0, 2'b00}) begin
            fails++; $display("FAIL bp_hold%0d: got v=%b data=%h id=%h rdy=%b required 1 30 0 00",
                              c, rspValid, rspData, rspId, reqReady);
         end
         @(negedge clk);
      end
      rspReady = 1'b1;
      #1;
      tests++;
      if (reqReady !== 2'b00) begin
         fails++; $display("FAIL bp_no_early_grant: got %b required 00", reqReady);
      end
      @(negedge clk);
      tests++;
      if ({rspValid, reqReady} !== 3'b010) begin
         fails++; $display("FAIL bp_release: got v=%b rdy=%b required 0 10", rspValid, reqReady);
      end
      @(negedge clk);
      reqValid[1] = 1'b0;
      waitRsp(ok);
      tests++;
      if ({ok, rspData, rspId, rspErr} !== {1'b1, 8'h3C, 1'b1, 1'b0}) begin
         fails++; $display("FAIL bp_next_rsp: got ok=%b data=%h id=%h err=%b required 1 3c 1 0",
                           ok, rspData, rspId, rspErr);
      end
      @(negedge clk);
   endtask

   task automatic test_illegal;
      bit ok;
      rspReady = 1'b1;
      setReq(1, 4'hC, 8'h12, 8'h34, 1'b1);
      @(negedge clk);
      reqValid[1] = 1'b0;
      waitRsp(ok);
      tests++;
      if ({ok, rspErr, rspData, rspId} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin
         fails++; $display("FAIL illegal_rsp: got ok=%b err=%b data=%h id=%h required 1 1 00 1",
                           ok, rspErr, rspData, rspId);
      end
      @(negedge clk);
   endtask

   task automatic test_withdrawal;
      bit ok;
      int spurious = 0;
      rspReady = 1'b1;
      setReq(0, kADD, 8'h01, 8'h02, 1'b1);
      @(negedge clk);
      reqValid[0] = 1'b0;
      setReq(1, kXOR, 8'hAA, 8'h55, 1'b1);
      #1;
      tests++;
      if (reqReady !== 2'b00) begin
         fails++; $display("FAIL wd_busy_ready: got %b required 00", reqReady);
      end
      @(negedge clk);
      reqValid[1] = 1'b0;
      waitRsp(ok);
      tests++;
      if ({ok, rspData, rspId} !== {1'b1, 8'h03, 1'b0}) begin
         fails++; $display("FAIL wd_rsp: got ok=%b data=%h id=%h required 1 03 0", ok, rspData, rspId);
      end
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         if (rspValid || busy || reqReady != 2'b00) spurious++;
         @(negedge clk);
      end
      tests++;
      if (spurious !== 0) begin
         fails++; $display("FAIL wd_spurious: got %0d active cycles required 0", spurious);
      end
   endtask

   task automatic test_reset_mid_and_round_robin;
      bit ok;
      logic [0:0] expId;
      logic [W-1:0] expData;
      rspReady = 1'b0;
      setReq(0, kSUB, 8'h09, 8'h04, 1'b1);
      @(negedge clk);
      reqValid[0] = 1'b0;
      waitRsp(ok);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({ok, rspValid, busy, aluOp} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
         fails++; $display("FAIL reset_mid: got ok=%b v=%b busy=%b op=%h required 1 0 0 0",
                           ok, rspValid, busy, aluOp);
      end
      @(negedge clk);
      rst_n = 1'b1;
      rspReady = 1'b1;
      setReq(0, kSUB, 8'h09, 8'h04, 1'b1);
      setReq(1, kXOR, 8'hF0, 8'h0F, 1'b1);
      #1;
      tests++;
      if (reqReady !== 2'b01) begin
         fails++; $display("FAIL rr_first_grant: got %b required 01", reqReady);
      end
      for (int r = 0; r < 4; r++) begin
         expId   = 1'(r % 2);
         expData = (r % 2 == 0) ? 8'h05 : 8'hFF;
         waitRsp(ok);
         tests++;
         if ({ok, rspId, rspData} !== {1'b1, expId, expData}) begin
            fails++; $display("FAIL rr_rsp%0d: got ok=%b id=%h data=%h required 1 %h %h",
                              r, ok, rspId, rspData, expId, expData);
         end
         @(negedge clk);
      end
      reqValid = '0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_illegal();
      test_withdrawal();
      test_reset_mid_and_round_robin();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
